multiple3_detector: RTL and testbench

- Serial divisibility-by-3 detector.
- Consumes one bit per clock, MSB first, forming an unbounded binary number N.
- Continuously flags whether N, formed from all bits since the last reset, is a multiple of 3.
- Small leaf block used as a stream checker; it has no handshake and accepts one bit on every clock edge.

---
 rtl/multiple3_pkg.sv | 16 +
 rtl/multiple3_detector.sv | 45 ++++
 tb/tb_multiple3_detector.sv | 132 +++++++++++++
 3 files changed

// File: rtl/multiple3_pkg.sv
// multiple3_pkg
//   Shared definitions for the serial divisibility-by-3 detector.
//   The state is the running remainder N mod 3, so the numeric code of
//   each state equals the remainder it represents.
package multiple3_pkg;

    localparam int REM_W = 2;

    typedef enum logic [REM_W-1:0] {
        R0    = 2'b00,
        R1    = 2'b01,
        R2    = 2'b10,
        R_BAD = 2'b11   // unreachable in normal operation; recovers to R0
    } rem_e;

endpackage : multiple3_pkg

// File: rtl/multiple3_detector.sv
// multiple3_detector
//   Serial divisibility-by-3 detector. One bit is taken per clock, MSB first,
//   building an unbounded number N. Only N mod 3 is stored, so the stream
//   may run forever.
//
// Ports
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; restarts N at 0 (Bit ignored that edge)
//   Bit   : next serial bit of N, MSB first
//   out   : 1 when N so far is a multiple of 3 (Moore, from state register)
module multiple3_detector
    import multiple3_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic Bit,
    output logic out
);

    // Simulation starts in R0; silicon is undefined until the first reset.
    rem_e r_q = R0;
    rem_e r_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= R0;
        end else begin
            r_q <= r_d;
        end
    end

    // Appending bit b to N gives 2N+b, so r' = (2r + b) mod 3.
    always_comb begin
        r_d = R0;
        unique case (r_q)
            R0:      r_d = Bit ? R1 : R0;
            R1:      r_d = Bit ? R0 : R2;
            R2:      r_d = Bit ? R2 : R1;
            default: r_d = R0;   // illegal code self-recovers
        endcase
    end

    assign out = (r_q == R0);

endmodule : multiple3_detector

// File: tb/tb_multiple3_detector.sv
module tb_multiple3_detector;
    import multiple3_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic Bit = 1'b0;
    logic out;

    int checks = 0;
    int failures = 0;

    multiple3_detector dut (
        .clk   (clk),
        .reset (reset),
        .Bit   (Bit),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic b;
        logic exp_out;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic b, input logic e, input string n);
        vec_t v;
        v.rst = r; v.b = b; v.exp_out = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: out=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic b);
        @(negedge clk);
        reset = r;
        Bit   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rem;
        logic held;

        // Reset then idle
        add(1, 0, 1, "idle_rst");
        for (int i = 0; i < 4; i++) add(0, 0, 1, "idle_zero");
        // Canonical stream: N = 0,1,3,6,12,25
        add(1, 0, 1, "canon_rst");
        add(0, 0, 1, "canon_N0");
        add(0, 1, 0, "canon_N1");
        add(0, 1, 1, "canon_N3");
        add(0, 0, 1, "canon_N6");
        add(0, 0, 1, "canon_N12");
        add(0, 1, 0, "canon_N25");
        // Remainder-2 path: N = 1,2,5,10,21
        add(1, 0, 1, "r2_rst");
        add(0, 1, 0, "r2_N1");
        add(0, 0, 0, "r2_N2");
        add(0, 1, 0, "r2_N5");
        add(0, 0, 0, "r2_N10");
        add(0, 1, 1, "r2_N21");
        // Reset mid-operation, Bit on the reset edge must be ignored
        add(1, 0, 1, "mid_rst0");
        add(0, 1, 0, "mid_N1");
        add(0, 0, 0, "mid_N2");
        add(1, 1, 1, "mid_rst_bit1");
        add(0, 1, 0, "mid_after_N1");

        #1;
        check("powerup", out, 1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].b);
            check(vecs[i].name, out, vecs[i].exp_out);
        end

        // Long random stream against an arithmetic model of N mod 3
        step(1, 0);
        rem = 0;
        for (int i = 0; i < 1000; i++) begin
            logic r, b;
            r = ($urandom_range(0, 49) == 0);
            b = 1'($urandom_range(0, 1));
            step(r, b);
            if (r) rem = 0;
            else   rem = (rem * 2 + int'(b)) % 3;
            check("rand", out, (rem == 0));
            // Toggle Bit mid-cycle; out must hold until the next edge
            if (i % 10 == 0) begin
                held = (rem == 0);
                #2 Bit = ~Bit;
                #1 check("rand_hold", out, held);
            end
        end

        // Illegal-state recovery
        step(1, 0);
        @(negedge clk);
        reset = 1'b0;
        Bit   = 1'b1;
        force dut.r_q = R_BAD;
        #1;
        release dut.r_q;
        #1;
        check("illegal_out", out, 1'b0);
        @(posedge clk);
        #1;
        check("illegal_recover_out", out, 1'b1);
        checks++;
        if (dut.r_q !== R0) begin
            failures++;
            $display("FAIL illegal_recover_state: r=%b expected=%b", dut.r_q, R0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multiple3_detector
